// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential fetch stage with credit-limited prefetch FIFO and redirect flush
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     stall_i,
    output logic                     im_req_o,
    output logic [XLEN-1:0]          im_addr_o,
    input  logic                     im_gnt_i,
    input  logic                     im_rvalid_i,
    input  logic [ILEN-1:0]          im_rdata_i,
    output logic [ILEN-1:0]          inst_o,
    output logic [XLEN-1:0]          inst_pc_o,
    output logic                     inst_valid_o,
    output logic [$clog2(DEPTH):0]   outstanding_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [ILEN-1:0] fifo_data [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW:0]     credits_used;
    logic [XLEN-1:0] target_pc;
    logic            fire;
    logic            push;
    logic            pop;

    // Queued words plus in-flight requests never exceed DEPTH, so the FIFO cannot overflow.
    assign credits_used  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign im_req_o      = rst_n_i && !redirect_i && (credits_used < (CW+1)'(DEPTH));
    assign im_addr_o     = fetch_pc;
    assign outstanding_o = outstanding;
    assign target_pc     = redirect_pc_i & ~XLEN'(3);

    assign fire = im_req_o && im_gnt_i;
    assign push = im_rvalid_i && !redirect_i && (discard == '0);
    assign pop  = !redirect_i && !stall_i && (fifo_count != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_i) begin
            // A response landing in the redirect cycle is stale too, so it leaves the discard budget.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= outstanding - CW'(im_rvalid_i);
            discard     <= outstanding - CW'(im_rvalid_i);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(fire) - CW'(im_rvalid_i);
            if (im_rvalid_i && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_data[wr_ptr] <= im_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (redirect_i) begin
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (fifo_count != '0) begin
                inst_o       <= fifo_data[rd_ptr];
                inst_pc_o    <= fifo_pc[rd_ptr];
                inst_valid_o <= 1'b1;
            end else begin
                inst_o       <= '0;
                inst_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised next-generation fetch stage with a decoupled instruction prefetch queue.
- Generates its own sequential fetch PC and issues pipelined requests to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Buffers returned words in a DEPTH-entry FIFO and presents one registered instruction plus its PC to decode.
- Supports stall from decode, and redirect (branch taken / jump) with flush of both queued and in-flight fetches.

Parameters:
XLEN, 32, width of PC and address fields
ILEN, 32, instruction word width
DEPTH, 4, FIFO entries; also the maximum number of outstanding memory requests (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
redirect_i  in  1  branch taken or jump from execute; flush and refetch
redirect_pc_i  in  XLEN  new fetch target, valid with redirect_i
stall_i  in  1  decode cannot accept; hold output register
im_req_o  out  1  memory request valid
im_addr_o  out  XLEN  request address (word aligned)
im_gnt_i  in  1  memory accepts request this cycle
im_rvalid_i  in  1  read data valid; responses return in request order
im_rdata_i  in  ILEN  read data
inst_o  out  ILEN  instruction to decode; 0 when not valid (bubble)
inst_pc_o  out  XLEN  PC of inst_o
inst_valid_o  out  1  inst_o holds a real instruction
outstanding_o  out  $clog2(DEPTH)+1  in-flight request count (debug/perf)

Behaviour:
Reset (async, rst_n_i low):
- fetch_pc = resp_pc = RESET_PC; FIFO empty; outstanding = discard = 0.
- Outputs: inst_o=0, inst_pc_o=0, inst_valid_o=0, im_req_o=0. im_addr_o follows fetch_pc.
- Asserting reset mid-operation drops all state; memory is reset with the core.

Request side:
- im_req_o = !redirect_i && (fifo_count + outstanding) < DEPTH. This is the credit rule; FIFO never overflows.
- im_addr_o = fetch_pc, combinational from register.
- On im_req_o && im_gnt_i: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding++.
- im_addr_o holds stable while req is high without gnt.

Response side:
- On im_rvalid_i: outstanding--.
- If discard>0: discard--, data dropped.
- Otherwise push {resp_pc, im_rdata_i} into the FIFO and set resp_pc += 4.
- Grant and rvalid in the same cycle leave outstanding unchanged.

Output register, evaluated in priority order each cycle:
1. redirect_i: inst_o<=0, inst_valid_o<=0, inst_pc_o holds.
2. stall_i: all output regs hold; no pop.
3. FIFO non-empty: load head into inst_o/inst_pc_o, inst_valid_o<=1, pop.
4. FIFO empty: inst_o<=0, inst_valid_o<=0.

Latency:
- rvalid at edge N writes the FIFO at edge N; the word appears on inst_o after edge N+1.
- No FIFO bypass.
- Back-to-back single-cycle memory gives one instruction per cycle in steady state.

Redirect, in the cycle redirect_i=1:
- FIFO cleared.
- fetch_pc and resp_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
- No request issued.
- discard <= outstanding minus any response arriving this cycle. That response is itself dropped and counts as its own discard.
- New requests may issue from the next cycle, even while discard>0; credits still include discarded in-flight requests.
- Redirect while stall_i=1: redirect wins; bubble inserted.
- Consecutive redirects: the last one wins; discard is recomputed each time.

Boundaries:
- FIFO full plus outstanding=DEPTH: im_req_o=0.
- Pop and push in the same cycle are both honoured.
- Wrap of fetch_pc at 2^XLEN-4 -> 0 is silent.

Test Plan:
- Reset, then single-cycle memory (gnt=1, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000) -> im_addr_o 0,4,8,...; inst_o/inst_pc_o valid from cycle 3, one per cycle, data matches PC.
- stall_i held 6 cycles with a fast memory -> inst_o frozen; im_req_o drops once fifo_count+outstanding=4; after release, no instruction lost or duplicated.
- 3-cycle memory latency, 3 requests outstanding, redirect_i to 32'h100 -> next cycle inst_valid_o=0; the 3 old responses are dropped; first valid inst_pc_o is 32'h100.
- redirect_i coincident with im_rvalid_i and stall_i -> that response is dropped; output becomes bubble (inst_o=0); discard count is correct.
- redirect_pc_i=32'h0000_0103 -> im_addr_o=32'h100; also redirect to 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n_i asserted asynchronously mid-burst -> outputs 0 immediately; fetch restarts at RESET_PC.
